button_debouncer: RTL and testbench

- Conditions the four raw DE0-Nano movement push-buttons before they reach the Avalon button PIO input port.
- Synchronises each asynchronous key, debounces it with a per-button stability counter, and presents a clean level bus for the PIO's `in_port`.
- Also emits single-cycle press/release/auto-repeat pulses, so game logic sees a held direction key as repeated moves.

---
 rtl/button_debouncer.sv | 175 +++++++++++++++++
 tb/tb_button_debouncer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : button_debouncer
//  Purpose  : Conditions raw push-button pins for the button PIO. Each key is
//             synchronised, polarity-normalised (1 = pressed) and debounced by
//             a per-button stability counter. Single-cycle press, release and
//             auto-repeat pulses are produced alongside the clean level.
//  Ports    : clk          - system clock
//             reset_n      - asynchronous, active-low reset
//             btn_raw      - raw key pins (asynchronous)
//             btn_level    - debounced level, 1 = pressed (PIO in_port)
//             btn_press    - 1-cycle pulse when a button becomes pressed
//             btn_release  - 1-cycle pulse when a button becomes released
//             btn_repeat   - 1-cycle pulse per auto-repeat while held
//             btn_move     - btn_press | btn_repeat
//  Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int NUM_BTN         = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat,
    output logic [NUM_BTN-1:0] btn_move
);

    // Pin level of a released key; synchronisers reset to it so a key held
    // through reset shows up as a fresh press afterwards.
    localparam logic             c_RELEASED  = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] c_DEB_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DLY_MAX   = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] c_PER_MAX   = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic             c_REPEAT_EN = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        logic             r_meta;
        logic             r_sync;
        logic [CNT_W-1:0] r_cnt;
        logic             r_stable;
        logic             r_press;
        logic             r_release;
        state_t           r_state;
        logic [CNT_W-1:0] r_timer;
        logic             r_repeat;
        logic             r_move;

        logic             w_pressed;
        logic             w_differ;
        logic             w_accept;
        logic             w_rise;
        logic             w_fall;
        logic             w_fire;

        // Two-flop synchroniser on the raw pin.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_meta <= c_RELEASED;
                r_sync <= c_RELEASED;
            end else begin
                r_meta <= btn_raw[gi];
                r_sync <= r_meta;
            end
        end

        assign w_pressed = r_sync ^ c_RELEASED;
        assign w_differ  = (w_pressed != r_stable);
        // The stable state flips on this edge; pulses are registered on the
        // same edge so they line up with the level change.
        assign w_accept  = w_differ && (r_cnt == c_DEB_MAX);
        assign w_rise    = w_accept && w_pressed;
        assign w_fall    = w_accept && !w_pressed;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt     <= '0;
                r_stable  <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= w_rise;
                r_release <= w_fall;
                if (!w_differ) begin
                    r_cnt <= '0;
                end else if (r_cnt < c_DEB_MAX) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else begin
                    r_stable <= w_pressed;
                    r_cnt    <= '0;
                end
            end
        end

        // A repeat fires when the timer expires, unless the level is
        // changing on this same edge (release wins, press restarts).
        always_comb begin
            w_fire = 1'b0;
            if (!w_accept) begin
                case (r_state)
                    S_DELAY:  w_fire = (r_timer == c_DLY_MAX);
                    S_REPEAT: w_fire = (r_timer == c_PER_MAX);
                    default:  w_fire = 1'b0;
                endcase
            end
        end

        // Repeat FSM; it reacts on the edge the press is registered, so the
        // press cycle is timer value 0.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state  <= S_IDLE;
                r_timer  <= '0;
                r_repeat <= 1'b0;
                r_move   <= 1'b0;
            end else begin
                r_repeat <= w_fire;
                r_move   <= w_rise | w_fire;
                if (w_fall) begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                end else if (w_rise) begin
                    r_timer <= '0;
                    r_state <= c_REPEAT_EN ? S_DELAY : S_IDLE;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            r_timer <= '0;
                        end
                        S_DELAY: begin
                            if (w_fire) begin
                                r_timer <= '0;
                                r_state <= S_REPEAT;
                            end else begin
                                r_timer <= r_timer + CNT_W'(1);
                            end
                        end
                        S_REPEAT: begin
                            if (w_fire) begin
                                r_timer <= '0;
                            end else begin
                                r_timer <= r_timer + CNT_W'(1);
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_timer <= '0;
                        end
                    endcase
                end
            end
        end

        assign btn_level[gi]   = r_stable;
        assign btn_press[gi]   = r_press;
        assign btn_release[gi] = r_release;
        assign btn_repeat[gi]  = r_repeat;
        assign btn_move[gi]    = r_move;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_debouncer
//  Purpose  : Directed self-checking bench for button_debouncer with
//             DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int c_NB  = 4;
    localparam int c_DEB = 8;
    localparam int c_RD  = 20;
    localparam int c_RP  = 5;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [c_NB-1:0] btn_raw = 4'b0000;
    logic [c_NB-1:0] btn_level;
    logic [c_NB-1:0] btn_press;
    logic [c_NB-1:0] btn_release;
    logic [c_NB-1:0] btn_repeat;
    logic [c_NB-1:0] btn_move;

    int checks   = 0;
    int failures = 0;

    logic [c_NB-1:0] s_press;
    logic [c_NB-1:0] s_release;
    logic [c_NB-1:0] s_repeat;
    logic [c_NB-1:0] s_move;

    logic [40:0] rep_hist;
    logic [40:0] move_hist;
    logic [40:0] exp_hist;

    button_debouncer #(
        .NUM_BTN         (c_NB),
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (c_DEB),
        .REPEAT_DELAY    (c_RD),
        .REPEAT_PERIOD   (c_RP),
        .CNT_W           (25)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat),
        .btn_move    (btn_move)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sticky();
        s_press   = '0;
        s_release = '0;
        s_repeat  = '0;
        s_move    = '0;
    endtask

    // One clock; outputs are sampled and inputs changed 1 ns after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            s_press   |= btn_press;
            s_release |= btn_release;
            s_repeat  |= btn_repeat;
            s_move    |= btn_move;
        end
    endtask

    initial begin
        clear_sticky();

        // ---------------- reset, keys held (raw 0 = pressed) ----------------
        tick(4);
        check("rst_level",   btn_level,   4'b0000);
        check("rst_press",   btn_press,   4'b0000);
        check("rst_release", btn_release, 4'b0000);
        check("rst_repeat",  btn_repeat,  4'b0000);
        check("rst_move",    btn_move,    4'b0000);
        reset_n = 1'b1;
        tick(9);
        check("init_level_early", btn_level, 4'b0000);
        tick(1);
        check("init_level", btn_level, 4'b1111);
        check("init_press", btn_press, 4'b1111);
        check("init_move",  btn_move,  4'b1111);
        tick(1);
        check("init_press_width", btn_press, 4'b0000);

        // release all keys
        btn_raw = 4'b1111;
        clear_sticky();
        tick(9);
        check("rel_all_early", btn_release, 4'b0000);
        tick(1);
        check("rel_all_level", btn_level,   4'b0000);
        check("rel_all_pulse", btn_release, 4'b1111);
        check("rel_all_norep", s_repeat,    4'b0000);
        tick(2);

        // ---------------- bounce rejection on bit 0 ----------------
        clear_sticky();
        for (int i = 0; i < 40; i++) begin
            btn_raw[0] = ((i / 3) % 2) != 0;
            tick(1);
        end
        btn_raw[0] = 1'b1;
        tick(15);
        check("bounce_level",   btn_level[0], 1'b0);
        check("bounce_press",   s_press,      4'b0000);
        check("bounce_release", s_release,    4'b0000);

        // ---------------- clean press/release on bit 2 ----------------
        btn_raw[2] = 1'b0;
        clear_sticky();
        tick(9);
        check("b2_level_early", btn_level, 4'b0000);
        tick(1);
        check("b2_level", btn_level, 4'b0100);
        check("b2_press", btn_press, 4'b0100);
        btn_raw[2] = 1'b1;
        tick(9);
        check("b2_rel_early", btn_release, 4'b0000);
        tick(1);
        check("b2_release",     btn_release, 4'b0100);
        check("b2_level_off",   btn_level,   4'b0000);
        check("b2_press_once",  s_press,     4'b0100);
        check("b2_no_repeat",   s_repeat,    4'b0000);
        tick(2);

        // ---------------- auto-repeat on bit 1 ----------------
        btn_raw[1] = 1'b0;
        tick(10);
        check("b1_press", btn_press, 4'b0010);
        check("b1_move",  btn_move,  4'b0010);
        check("b1_press_norep", btn_repeat, 4'b0000);
        rep_hist  = '0;
        move_hist = '0;
        exp_hist  = '0;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            rep_hist[k]  = btn_repeat[1];
            move_hist[k] = btn_move[1];
        end
        for (int k = c_RD; k <= 40; k += c_RP) exp_hist[k] = 1'b1;
        check("b1_repeat_times", rep_hist,  exp_hist);
        check("b1_move_times",   move_hist, exp_hist);
        btn_raw[1] = 1'b1;
        tick(10);
        // P+50 is both the release cycle and a would-be repeat slot
        check("b1_release",       btn_release, 4'b0010);
        check("b1_rel_no_repeat", btn_repeat,  4'b0000);
        check("b1_rel_no_move",   btn_move,    4'b0000);
        clear_sticky();
        tick(10);
        check("b1_idle_after_rel", s_repeat, 4'b0000);

        // ---------------- release during DELAY on bit 3 ----------------
        btn_raw[3] = 1'b0;
        tick(10);
        check("b3_press", btn_press, 4'b1000);
        tick(2);
        btn_raw[3] = 1'b1;
        clear_sticky();
        tick(10);
        check("b3_release_p12", btn_release, 4'b1000);
        tick(30);
        check("b3_no_repeat", s_repeat, 4'b0000);
        btn_raw[3] = 1'b0;
        tick(10);
        check("b3_repress", btn_press, 4'b1000);
        clear_sticky();
        tick(19);
        check("b3_repress_no_early_rep", s_repeat, 4'b0000);
        tick(1);
        check("b3_repress_repeat", btn_repeat, 4'b1000);
        btn_raw[3] = 1'b1;
        tick(12);

        // ---------------- reset mid-repeat on bit 1 ----------------
        btn_raw[1] = 1'b0;
        tick(10);
        check("mr_press", btn_press, 4'b0010);
        tick(27);
        clear_sticky();
        reset_n = 1'b0;
        #1;
        check("mr_async_level",  btn_level,  4'b0000);
        check("mr_async_repeat", btn_repeat, 4'b0000);
        tick(3);
        check("mr_no_pulses", {s_press, s_release, s_repeat, s_move}, 16'h0000);
        reset_n = 1'b1;
        tick(9);
        check("mr_level_early", btn_level, 4'b0000);
        tick(1);
        check("mr_repress", btn_press, 4'b0010);
        clear_sticky();
        tick(19);
        check("mr_no_early_rep", s_repeat, 4'b0000);
        tick(1);
        check("mr_first_repeat", btn_repeat, 4'b0010);
        tick(c_RP);
        check("mr_second_repeat", btn_repeat, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
